// File: rtl/pc_ctrl_ras_if.sv
// pc_ctrl_ras_if: control/decode <-> PC unit bundle.
//   master : drives stall and the next-PC select fields, observes PC/RAS state
//   slave  : the PC unit itself
// Signals:
//   stall, branch_taken, br_imm[15:0], jump, jal, jump_idx[25:0],
//   jr, jr_target[AW-1:0], use_ras           (master -> slave)
//   pc_out, pc_plus4, ras_top [AW-1:0], ras_empty, ras_full (slave -> master)
interface pc_ctrl_ras_if #(
    parameter int AW = 32
);
    logic          stall;
    logic          branch_taken;
    logic [15:0]   br_imm;
    logic          jump;
    logic          jal;
    logic [25:0]   jump_idx;
    logic          jr;
    logic [AW-1:0] jr_target;
    logic          use_ras;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] ras_top;
    logic          ras_empty;
    logic          ras_full;

    modport master (
        output stall, branch_taken, br_imm, jump, jal, jump_idx, jr, jr_target, use_ras,
        input  pc_out, pc_plus4, ras_top, ras_empty, ras_full
    );

    modport slave (
        input  stall, branch_taken, br_imm, jump, jal, jump_idx, jr, jr_target, use_ras,
        output pc_out, pc_plus4, ras_top, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_ctrl_ras.sv
// pc_ctrl_ras: MIPS-32 fetch-stage program counter with a circular
// return-address stack (RAS) that predicts jr $ra targets.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : pc_ctrl_ras_if.slave (select inputs in, pc_out/pc_plus4/RAS state out)
// Next-PC priority (unstalled): jr > jump|jal > branch_taken > pc+4.
// jal pushes pc+4 (no delay slot); jr with use_ras pops when the stack is non-empty.
// A full stack keeps accepting pushes by overwriting the oldest entry.
module pc_ctrl_ras #(
    parameter int          AW        = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    pc_ctrl_ras_if.slave bus
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;

    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] br_tgt;
    logic [AW-1:0] jmp_tgt;
    logic [AW-1:0] jr_tgt;
    logic [AW-1:0] ras_top;
    logic [AW-1:0] pc_next;
    logic [PW-1:0] ptr_inc;
    logic          ras_empty;
    logic          ras_full;
    logic          do_push;
    logic          do_pop;

    assign pc_plus4  = pc_q + AW'(4);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[ptr_q];
    // Depth is a power of two, so PW-bit pointer arithmetic wraps on its own.
    assign ptr_inc   = ptr_q + PW'(1);

    // Branch offset is in words: sign-extend then scale by 4.
    assign br_tgt = pc_plus4 + {{(AW-18){bus.br_imm[15]}}, bus.br_imm, 2'b00};

    // Region bits above the 28-bit jump field come from pc+4; none exist at AW=28.
    generate
        if (AW > 28) begin : g_jmp_region
            assign jmp_tgt = {pc_plus4[AW-1:28], bus.jump_idx, 2'b00};
        end else begin : g_jmp_flat
            assign jmp_tgt = {bus.jump_idx, 2'b00};
        end
    endgenerate

    assign jr_tgt = (bus.use_ras && !ras_empty) ? ras_top : bus.jr_target;

    always_comb begin
        pc_next = pc_plus4;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (bus.jr) begin
            pc_next = jr_tgt;
            do_pop  = bus.use_ras && !ras_empty;
        end else if (bus.jump || bus.jal) begin
            pc_next = jmp_tgt;
            do_push = bus.jal;
        end else if (bus.branch_taken) begin
            pc_next = br_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC[AW-1:0];
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (!bus.stall) begin
            pc_q <= pc_next;
            if (do_push) begin
                ras_mem[ptr_inc] <= pc_plus4;
                ptr_q            <= ptr_inc;
                // Saturate: once full, pushes overwrite the oldest slot.
                if (!ras_full) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else if (do_pop) begin
                // Popped entry stays in memory; only ptr/count move.
                ptr_q <= ptr_q - PW'(1);
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.ras_top   = ras_top;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
endmodule

// File: tb/tb_pc_ctrl_ras.sv
// Directed bench for pc_ctrl_ras (AW=32, RESET_VEC=0, RAS_DEPTH=4).
// Driver applies inputs at the falling edge, lets one rising edge happen and
// queues the hand-computed post-edge state; a monitor pops and compares on
// each falling edge.
module tb_pc_ctrl_ras;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_ctrl_ras_if #(.AW(32)) bus ();

    pc_ctrl_ras #(
        .AW       (32),
        .RESET_VEC(32'h0000_0000),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] top;
        logic        emp;
        logic        full;
    } exp_t;

    exp_t sbq[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.nm, ".pc"},    bus.pc_out,          e.pc);
            chk({e.nm, ".pc4"},   bus.pc_plus4,        e.pc + 32'd4);
            chk({e.nm, ".top"},   bus.ras_top,         e.top);
            chk({e.nm, ".empty"}, 32'(bus.ras_empty),  32'(e.emp));
            chk({e.nm, ".full"},  32'(bus.ras_full),   32'(e.full));
        end
    end

    task automatic push_exp(input string nm, input logic [31:0] epc, input logic [31:0] etop,
                            input logic eemp, input logic efull);
        exp_t e;
        e.nm = nm; e.pc = epc; e.top = etop; e.emp = eemp; e.full = efull;
        sbq.push_back(e);
    endtask

    // Inputs are applied at a falling edge; one rising edge; return at next falling edge.
    task automatic step(input string nm, input logic stl, input logic brt, input logic [15:0] imm,
                        input logic jmp, input logic jl, input logic [25:0] idx,
                        input logic jrr, input logic ur, input logic [31:0] tgt,
                        input logic [31:0] epc, input logic [31:0] etop,
                        input logic eemp, input logic efull);
        bus.stall = stl; bus.branch_taken = brt; bus.br_imm = imm;
        bus.jump = jmp; bus.jal = jl; bus.jump_idx = idx;
        bus.jr = jrr; bus.use_ras = ur; bus.jr_target = tgt;
        @(posedge clk);
        push_exp(nm, epc, etop, eemp, efull);
        @(negedge clk);
    endtask

    task automatic t_idle(input string nm, input logic [31:0] epc, input logic [31:0] etop,
                          input logic eemp, input logic efull);
        step(nm, 0, 0, 16'h0, 0, 0, 26'h0, 0, 0, 32'h0, epc, etop, eemp, efull);
    endtask

    task automatic t_jr(input string nm, input logic ur, input logic [31:0] tgt,
                        input logic [31:0] epc, input logic [31:0] etop,
                        input logic eemp, input logic efull);
        step(nm, 0, 0, 16'h0, 0, 0, 26'h0, 1, ur, tgt, epc, etop, eemp, efull);
    endtask

    task automatic t_jal(input string nm, input logic [25:0] idx,
                         input logic [31:0] epc, input logic [31:0] etop,
                         input logic eemp, input logic efull);
        step(nm, 0, 0, 16'h0, 0, 1, idx, 0, 0, 32'h0, epc, etop, eemp, efull);
    endtask

    task automatic t_br(input string nm, input logic [15:0] imm,
                        input logic [31:0] epc, input logic [31:0] etop,
                        input logic eemp, input logic efull);
        step(nm, 0, 1, imm, 0, 0, 26'h0, 0, 0, 32'h0, epc, etop, eemp, efull);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : drive
        bus.stall = 0; bus.branch_taken = 0; bus.br_imm = '0; bus.jump = 0;
        bus.jal = 0; bus.jump_idx = '0; bus.jr = 0; bus.jr_target = '0; bus.use_ras = 0;

        // 1: reset state, then sequential fetch
        push_exp("rst", 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        t_idle("seq1", 32'h4, 32'h0, 1, 0);
        t_idle("seq2", 32'h8, 32'h0, 1, 0);
        t_idle("seq3", 32'hC, 32'h0, 1, 0);

        // 2: branches, backward and forward
        t_jr("set100a", 0, 32'h100, 32'h100, 32'h0, 1, 0);
        t_br("br_neg", 16'hFFFE, 32'h0FC, 32'h0, 1, 0);
        t_jr("set100b", 0, 32'h100, 32'h100, 32'h0, 1, 0);
        t_br("br_pos", 16'h0003, 32'h110, 32'h0, 1, 0);

        // 3: jal then RAS-predicted return
        t_jr("set_1040", 0, 32'h1000_0040, 32'h1000_0040, 32'h0, 1, 0);
        t_jal("jal1", 26'h0000100, 32'h1000_0400, 32'h1000_0044, 0, 0);
        t_jr("ret1", 1, 32'h0000_DEAD, 32'h1000_0044, 32'h0, 1, 0);

        // 4: overflow by one, then drain and fall back to jr_target
        t_jal("p1", 26'h40,  32'h1000_0100, 32'h1000_0048, 0, 0);
        t_jal("p2", 26'h80,  32'h1000_0200, 32'h1000_0104, 0, 0);
        t_jal("p3", 26'hC0,  32'h1000_0300, 32'h1000_0204, 0, 0);
        t_jal("p4", 26'h100, 32'h1000_0400, 32'h1000_0304, 0, 1);
        t_jal("p5", 26'h140, 32'h1000_0500, 32'h1000_0404, 0, 1);
        t_jr("pop5", 1, 32'h000D_EAD0, 32'h1000_0404, 32'h1000_0304, 0, 0);
        t_jr("pop4", 1, 32'h000D_EAD0, 32'h1000_0304, 32'h1000_0204, 0, 0);
        t_jr("pop3", 1, 32'h000D_EAD0, 32'h1000_0204, 32'h1000_0104, 0, 0);
        t_jr("pop2", 1, 32'h000D_EAD0, 32'h1000_0104, 32'h0, 1, 0);
        t_jr("pop_mt", 1, 32'h0000_2000, 32'h0000_2000, 32'h0, 1, 0);

        // 5: stall during jal holds everything; push happens once on release
        step("stl1", 1, 0, 16'h0, 0, 1, 26'h900, 0, 0, 32'h0, 32'h2000, 32'h0, 1, 0);
        step("stl2", 1, 0, 16'h0, 0, 1, 26'h900, 1, 0, 32'h9999, 32'h2000, 32'h0, 1, 0);
        step("stl3", 1, 0, 16'h0, 0, 1, 26'h900, 0, 0, 32'h0, 32'h2000, 32'h0, 1, 0);
        t_jal("stl_rel", 26'h900, 32'h2400, 32'h2004, 0, 0);
        t_jr("stl_ret", 1, 32'h7000, 32'h2004, 32'h0, 1, 0);

        // 6: wrap, jr/jal and jump/jal collisions, priorities
        t_jr("set_top", 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1, 0);
        t_idle("wrap", 32'h0, 32'h0, 1, 0);
        step("jr_jal", 0, 0, 16'h0, 0, 1, 26'h50, 1, 0, 32'h300, 32'h300, 32'h0, 1, 0);
        step("j_jal", 0, 0, 16'h0, 1, 1, 26'h10, 0, 0, 32'h0, 32'h40, 32'h304, 0, 0);
        step("jmp", 0, 0, 16'h0, 1, 0, 26'h20, 0, 0, 32'h0, 32'h80, 32'h304, 0, 0);
        step("br_jmp", 0, 1, 16'h0005, 1, 0, 26'h30, 0, 0, 32'h0, 32'hC0, 32'h304, 0, 0);
        t_jr("jr_noras", 0, 32'h500, 32'h500, 32'h304, 0, 0);
        step("jr_jal_pop", 0, 0, 16'h0, 0, 1, 26'h50, 1, 1, 32'h600, 32'h304, 32'h0, 1, 0);
        t_jal("pre_rst", 26'h100, 32'h400, 32'h308, 0, 0);

        // mid-operation async reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("async_pc", bus.pc_out, 32'h0);
        chk("async_emp", 32'(bus.ras_empty), 32'h1);
        push_exp("mid_rst", 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        t_idle("post_rst", 32'h4, 32'h0, 1, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
